// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the forwarding/interlock slice.
//   - default register-index and data widths
//   - md_state_t: multi-cycle tracker states
//   - prioSel(): lowest-set-bit priority select used for youngest-first matching
package fwd_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;

   // Widest stage-match vector prioSel() handles; NO_SEL means "no bit set".
   localparam int MAX_STG = 16;
   localparam int IDX_W   = 5;
   localparam logic [IDX_W-1:0] NO_SEL = IDX_W'(MAX_STG);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   // Index of the lowest set bit (youngest stage wins); NO_SEL when empty.
   function automatic logic [IDX_W-1:0] prioSel(input logic [MAX_STG-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = NO_SEL;
      for (int i = MAX_STG - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/md_tracker.sv
// md_tracker: tracks one multi-cycle multiply/divide op writing LO/HI.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   startOk      op issued this cycle and not held by a stall
//   latency      op latency in cycles (0 behaves as 1)
//   busy         tracker in BUSY (result pending)
//   done         result valid this cycle (one cycle per op)
module md_tracker
   import fwd_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             startOk,
   input  logic [CNT_W-1:0] latency,
   output logic             busy,
   output logic             done
);

   md_state_t        state_r;
   md_state_t        stateNext_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cntNext_s;

   // State and remaining-cycle counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= stateNext_s;
         cnt_r   <= cntNext_s;
      end
   end

   // Next-state logic; a start during BUSY is ignored (the top level stalls it)
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      case (state_r)
         IDLE, DONE: begin
            if (startOk) begin
               if (latency <= CNT_W'(1'b1)) begin
                  stateNext_s = DONE;
                  cntNext_s   = '0;
               end else begin
                  stateNext_s = BUSY;
                  cntNext_s   = latency - CNT_W'(1'b1);
               end
            end else begin
               stateNext_s = IDLE;
               cntNext_s   = '0;
            end
         end
         BUSY: begin
            if (cnt_r == CNT_W'(1'b1)) begin
               stateNext_s = DONE;
               cntNext_s   = '0;
            end else begin
               stateNext_s = BUSY;
               cntNext_s   = cnt_r - CNT_W'(1'b1);
            end
         end
         default: begin
            stateNext_s = IDLE;
            cntNext_s   = '0;
         end
      endcase
   end

   assign busy = (state_r == BUSY);
   assign done = (state_r == DONE);

endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: EX-stage operand bypass selection and interlock.
// Selects bypass data for NUM_SRC operands from NUM_STG downstream stages
// (index 0 youngest), forwards LO/HI to operand 0, tracks the multi-cycle
// unit and raises stall for load-use and busy-LO/HI hazards.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   src_reg, src_use                 EX operand indices / operand-read flags
//   ex_use_lo, ex_use_hi, ex_wr_lohi EX instruction LO/HI usage
//   stg_wr_reg, stg_ready, stg_data  per-stage GPR destination, valid, data
//   stg_wr_lohi, stg_lo, stg_hi      per-stage LO/HI write and data
//   md_start, md_cycles              multi-cycle op issue and latency
//   md_lo, md_hi                     multi-cycle result (valid with md_done)
//   src_fwd, src_fwd_data            per-operand bypass select and data
//   stall                            hold IF/ID/EX, bubble into MEM
//   md_busy, md_done                 tracker status
//   stall_cnt                        saturating stalled-cycle count
// Build option: define FWD_HOLD_EN to add a one-entry hold register that
// re-forwards the oldest stage's write for one more cycle.
module forward_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int NUM_STG = 2,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int CNT_W   = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_SRC*REG_W-1:0]   src_reg,
   input  logic [NUM_SRC-1:0]         src_use,
   input  logic                       ex_use_lo,
   input  logic                       ex_use_hi,
   input  logic                       ex_wr_lohi,
   input  logic [NUM_STG*REG_W-1:0]   stg_wr_reg,
   input  logic [NUM_STG-1:0]         stg_ready,
   input  logic [NUM_STG*DATA_W-1:0]  stg_data,
   input  logic [NUM_STG-1:0]         stg_wr_lohi,
   input  logic [NUM_STG*DATA_W-1:0]  stg_lo,
   input  logic [NUM_STG*DATA_W-1:0]  stg_hi,
   input  logic                       md_start,
   input  logic [CNT_W-1:0]           md_cycles,
   input  logic [DATA_W-1:0]          md_lo,
   input  logic [DATA_W-1:0]          md_hi,
   output logic [NUM_SRC-1:0]         src_fwd,
   output logic [NUM_SRC*DATA_W-1:0]  src_fwd_data,
   output logic                       stall,
   output logic                       md_busy,
   output logic                       md_done,
   output logic [31:0]                stall_cnt
);

   localparam int OLD = NUM_STG - 1;

   logic                      loadUse_s;
   logic [NUM_SRC-1:0]        gprFwd_s;
   logic [NUM_SRC*DATA_W-1:0] gprData_s;
   logic [MAX_STG-1:0]        gprMatch_s;
   logic [IDX_W-1:0]          gprSel_s;
   logic                      lohiHit_s;
   logic [DATA_W-1:0]         lohiData_s;
   logic [MAX_STG-1:0]        lohiMatch_s;
   logic [IDX_W-1:0]          lohiSel_s;
   logic [31:0]               stallCnt_r;

   logic                      holdValid_r;
   logic [REG_W-1:0]          holdReg_r;
   logic [DATA_W-1:0]         holdData_r;
   logic                      holdLohiValid_r;
   logic [DATA_W-1:0]         holdLo_r;
   logic [DATA_W-1:0]         holdHi_r;

   md_tracker #(.CNT_W(CNT_W)) uTracker (
      .clk     (clk),
      .rst_n   (rst_n),
      .startOk (md_start & ~loadUse_s),
      .latency (md_cycles),
      .busy    (md_busy),
      .done    (md_done)
   );

   // GPR bypass: youngest matching stage decides; a not-ready match stalls
   // and older stages are not consulted past it
   always_comb begin
      loadUse_s  = 1'b0;
      gprFwd_s   = '0;
      gprData_s  = '0;
      gprMatch_s = '0;
      gprSel_s   = NO_SEL;
      for (int i = 0; i < NUM_SRC; i++) begin
         gprMatch_s = '0;
         for (int s = 0; s < NUM_STG; s++) begin
            gprMatch_s[s] = (stg_wr_reg[s*REG_W +: REG_W] == src_reg[i*REG_W +: REG_W]);
         end
         gprSel_s = prioSel(gprMatch_s);
         if (src_use[i] && (src_reg[i*REG_W +: REG_W] != '0)) begin
            if (gprSel_s != NO_SEL) begin
               for (int s = 0; s < NUM_STG; s++) begin
                  if (IDX_W'(s) == gprSel_s) begin
                     if (stg_ready[s]) begin
                        gprFwd_s[i]                 = 1'b1;
                        gprData_s[i*DATA_W +: DATA_W] = stg_data[s*DATA_W +: DATA_W];
                     end else begin
                        loadUse_s = 1'b1;
                     end
                  end else begin
                     gprFwd_s[i] = gprFwd_s[i];
                  end
               end
            end else if (holdValid_r && (holdReg_r == src_reg[i*REG_W +: REG_W])) begin
               gprFwd_s[i]                 = 1'b1;
               gprData_s[i*DATA_W +: DATA_W] = holdData_r;
            end else begin
               gprFwd_s[i] = 1'b0;
            end
         end else begin
            gprFwd_s[i] = 1'b0;
         end
      end
   end

   // LO/HI bypass for operand 0: tracker result, then stages, then hold;
   // HI is chosen when both LO and HI are read
   always_comb begin
      lohiHit_s   = 1'b0;
      lohiData_s  = '0;
      lohiMatch_s = '0;
      lohiMatch_s[NUM_STG-1:0] = stg_wr_lohi;
      lohiSel_s   = prioSel(lohiMatch_s);
      if (ex_use_lo || ex_use_hi) begin
         if (md_done) begin
            lohiHit_s  = 1'b1;
            lohiData_s = ex_use_hi ? md_hi : md_lo;
         end else if (lohiSel_s != NO_SEL) begin
            lohiHit_s = 1'b1;
            for (int s = 0; s < NUM_STG; s++) begin
               if (IDX_W'(s) == lohiSel_s) begin
                  lohiData_s = ex_use_hi ? stg_hi[s*DATA_W +: DATA_W]
                                         : stg_lo[s*DATA_W +: DATA_W];
               end else begin
                  lohiData_s = lohiData_s;
               end
            end
         end else if (holdLohiValid_r) begin
            lohiHit_s  = 1'b1;
            lohiData_s = ex_use_hi ? holdHi_r : holdLo_r;
         end else begin
            lohiHit_s = 1'b0;
         end
      end else begin
         lohiHit_s = 1'b0;
      end
   end

   // Operand 0 takes the LO/HI bypass over any GPR bypass
   always_comb begin
      src_fwd      = gprFwd_s;
      src_fwd_data = gprData_s;
      if (lohiHit_s) begin
         src_fwd[0]               = 1'b1;
         src_fwd_data[DATA_W-1:0] = lohiData_s;
      end else begin
         src_fwd[0] = gprFwd_s[0];
      end
   end

   assign stall = loadUse_s | (md_busy & (ex_use_lo | ex_use_hi | ex_wr_lohi | md_start));

`ifdef FWD_HOLD_EN
   // Hold register: keeps the oldest stage's write visible for one more cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holdValid_r     <= 1'b0;
         holdReg_r       <= '0;
         holdData_r      <= '0;
         holdLohiValid_r <= 1'b0;
         holdLo_r        <= '0;
         holdHi_r        <= '0;
      end else begin
         if (stg_ready[OLD] && (stg_wr_reg[OLD*REG_W +: REG_W] != '0)) begin
            holdValid_r <= 1'b1;
            holdReg_r   <= stg_wr_reg[OLD*REG_W +: REG_W];
            holdData_r  <= stg_data[OLD*DATA_W +: DATA_W];
         end else begin
            holdValid_r <= 1'b0;
            holdReg_r   <= '0;
            holdData_r  <= '0;
         end
         // The tracker result is the newest LO/HI value, so it wins the capture
         if (md_done) begin
            holdLohiValid_r <= 1'b1;
            holdLo_r        <= md_lo;
            holdHi_r        <= md_hi;
         end else if (stg_wr_lohi[OLD]) begin
            holdLohiValid_r <= 1'b1;
            holdLo_r        <= stg_lo[OLD*DATA_W +: DATA_W];
            holdHi_r        <= stg_hi[OLD*DATA_W +: DATA_W];
         end else begin
            holdLohiValid_r <= 1'b0;
            holdLo_r        <= '0;
            holdHi_r        <= '0;
         end
      end
   end
`else
   assign holdValid_r     = 1'b0;
   assign holdReg_r       = '0;
   assign holdData_r      = '0;
   assign holdLohiValid_r = 1'b0;
   assign holdLo_r        = '0;
   assign holdHi_r        = '0;
`endif

   // Saturating count of stalled cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_r <= 32'd0;
      end else if (stall && (stallCnt_r != 32'hFFFF_FFFF)) begin
         stallCnt_r <= stallCnt_r + 32'd1;
      end else begin
         stallCnt_r <= stallCnt_r;
      end
   end

   assign stall_cnt = stallCnt_r;

endmodule
